// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer that shares one combinational
// ALU among NUM_REQ requesters.
//
// A single operation is accepted at a time over a valid/ready handshake. Its
// operands, opcode and requester index are latched, the operation runs through
// the ALU for one cycle, and the result is registered and held until the
// consumer accepts it.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b, req_op  per-requester operands and opcode
//   req_lock              keep the grant for the next op (ALU_ARB_LOCK_EN only)
//   rsp_valid/rsp_ready   result handshake
//   rsp_id                index of the requester that owns the result
//   rsp_s                 ALU result
//   rsp_zero              rsp_s is all zeros
//   rsp_err               opcode was not AND/OR/ADD/SUB/SLT/SLTU/NOR
//
// Build option: define ALU_ARB_LOCK_EN to add req_lock and locked re-grant.

package alu_arbiter_pkg;
   typedef logic [31:0] bus_t;
   typedef logic [3:0]  ula_oper_t;

   localparam ula_oper_t ULA_AND  = 4'b0000;
   localparam ula_oper_t ULA_OR   = 4'b0001;
   localparam ula_oper_t ULA_ADD  = 4'b0010;
   localparam ula_oper_t ULA_SLTU = 4'b0011;
   localparam ula_oper_t ULA_SUB  = 4'b0110;
   localparam ula_oper_t ULA_SLT  = 4'b0111;
   localparam ula_oper_t ULA_NOR  = 4'b1100;
endpackage

// Shared combinational ALU. Unknown opcodes give s = 0 and err = 1.
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
(
   input  bus_t      a,
   input  bus_t      b,
   input  ula_oper_t op,
   output bus_t      s,
   output logic      err
);
   always_comb begin
      s   = '0;
      err = 1'b0;
      unique case (op)
         ULA_AND:  s = a & b;
         ULA_OR:   s = a | b;
         ULA_ADD:  s = a + b;
         ULA_SUB:  s = a - b;
         ULA_SLT:  s = {31'b0, $signed(a) < $signed(b)};
         ULA_SLTU: s = {31'b0, a < b};
         ULA_NOR:  s = ~(a | b);
         default:  err = 1'b1;
      endcase
   end
endmodule

module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REQ-1:0]  req_valid,
   output logic [NUM_REQ-1:0]  req_ready,
   input  bus_t                req_a [NUM_REQ],
   input  bus_t                req_b [NUM_REQ],
   input  ula_oper_t           req_op [NUM_REQ],
`ifdef ALU_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]  req_lock,
`endif
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [ID_W-1:0]     rsp_id,
   output bus_t                rsp_s,
   output logic                rsp_zero,
   output logic                rsp_err
);
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] last_grant_q, last_grant_d;
   bus_t            a_q, a_d, b_q, b_d;
   ula_oper_t       op_q, op_d;
   logic [ID_W-1:0] id_q, id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   bus_t            rsp_s_q, rsp_s_d;
   logic            rsp_zero_q, rsp_zero_d;
   logic            rsp_err_q, rsp_err_d;
`ifdef ALU_ARB_LOCK_EN
   logic            lock_q, lock_d;
`endif

   logic            any_valid;
   logic [ID_W-1:0] winner;
   bus_t            alu_s;
   logic            alu_err;

   alu_arbiter_alu u_alu (
      .a   (a_q),
      .b   (b_q),
      .op  (op_q),
      .s   (alu_s),
      .err (alu_err)
   );

   // Round-robin search starting just after the last grant.
   always_comb begin
      logic [ID_W-1:0] cand;
      any_valid = 1'b0;
      winner    = last_grant_q;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((32'(last_grant_q) + i) % NUM_REQ);
         if (!any_valid && req_valid[cand]) begin
            any_valid = 1'b1;
            winner    = cand;
         end
      end
`ifdef ALU_ARB_LOCK_EN
      // A locked owner that is still requesting overrides round-robin order.
      if (lock_q && req_valid[last_grant_q]) begin
         any_valid = 1'b1;
         winner    = last_grant_q;
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_s_d      = rsp_s_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
`ifdef ALU_ARB_LOCK_EN
      lock_d       = lock_q;
`endif
      req_ready    = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               req_ready[winner] = 1'b1;
               a_d          = req_a[winner];
               b_d          = req_b[winner];
               op_d         = req_op[winner];
               id_d         = winner;
               last_grant_d = winner;
`ifdef ALU_ARB_LOCK_EN
               lock_d       = req_lock[winner];
`endif
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_s_d     = alu_s;
            rsp_zero_d  = (alu_s == '0);
            rsp_err_d   = alu_err;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         id_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_s_q      <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
         lock_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_s_q      <= rsp_s_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
`ifdef ALU_ARB_LOCK_EN
         lock_q       <= lock_d;
`endif
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_s     = rsp_s_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_err   = rsp_err_q;
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational ALU datapath between `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake, latches operands and opcode, runs them through an internally instantiated ALU, and returns a registered result tagged with the requester index. It sits between the issue stages (or multi-cycle units) that need arithmetic and the one shared ALU instance.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester index; derived, not overridden.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  `NUM_REQ`  per-requester request valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept; one-hot or zero.
- `req_a`, `req_b`  in  `NUM_REQ` x `bus_t`  operands.
- `req_op`  in  `NUM_REQ` x `ula_oper_t`  operation.
- `req_lock`  in  `NUM_REQ`  keep grant after this op; present only with `ALU_ARB_LOCK_EN`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  `ID_W`  index of the requester that owns the result.
- `rsp_s`  out  `bus_t`  ALU result.
- `rsp_zero`  out  1  high when `rsp_s` is all zeros.
- `rsp_err`  out  1  high when the op was not AND/OR/ADD/SUB/SLT/SLTU/NOR.

## Operation

- FSM states: IDLE, EXEC, RESP.
- IDLE: select a winner among asserted `req_valid` by round-robin, starting at `last_grant+1` modulo `NUM_REQ`. Drive `req_ready` high for the winner only, combinationally. On `req_valid & req_ready`: latch a, b, op and id; set `last_grant` to the winner; go to EXEC. With no valid requests, stay in IDLE and drive `req_ready` = 0.
- EXEC: present the latched operands and op to the ALU. Register the result into `rsp_s`, compute `rsp_zero` = (`rsp_s` == 0) and `rsp_err`, set `rsp_valid` = 1, and go to RESP.
- RESP: hold `rsp_*` stable while `rsp_valid`=1 and `rsp_ready`=0. On `rsp_ready`=1, clear `rsp_valid` and go to IDLE.
- Illegal opcode: `rsp_s` = 0, `rsp_zero` = 1, `rsp_err` = 1. This is still a normal response, and the FSM does not stall.
- Zero flag is produced by this block as a single bit. The ALU's own zero output is unused.
- Requesters must hold valid and operands stable until they see ready. Dropping valid before ready is legal and simply forfeits that request.
- `req_ready` is 0 in EXEC and RESP for all requesters.

## Timing

- Reset values: FSM = IDLE, `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_s` = 0, `rsp_zero` = 0, `rsp_err` = 0, `last_grant` = `NUM_REQ-1` (requester 0 wins first).
- Latency: accept at edge N, result valid after edge N+1, earliest `rsp_ready` handshake at edge N+2, next accept at edge N+3. Peak throughput is one op per 3 cycles.
- Simultaneous requests: exactly one is granted per IDLE cycle. Losers keep valid and are served in round-robin order, so there is no starvation: each requester waits at most `NUM_REQ-1` ops.
- Reset during EXEC or RESP: the in-flight op is discarded with no response, all outputs return to their reset values immediately, and the request is not replayed.
- `rsp_ready` asserted while `rsp_valid` = 0 is ignored.

## Configuration

- `ALU_ARB_LOCK_EN` defined: adds the `req_lock` port. If the granted requester had `req_lock` high at acceptance, the next IDLE arbitration grants that same requester, provided its `req_valid` is high, regardless of round-robin order. If its `req_valid` is low, normal round-robin applies. This supports atomic back-to-back sequences.
- `ALU_ARB_LOCK_EN` not defined: no `req_lock` port, pure round-robin.

## Test plan

- Single op: requester 0 sends ADD, a=5, b=3. Required: `req_ready[0]` high in the same cycle; two edges later `rsp_valid`=1, `rsp_s`=8, `rsp_zero`=0, `rsp_id`=0.
- Zero and SLT: SUB with a=3, b=3 gives `rsp_s`=0 and `rsp_zero`=1. SLT with a=2, b=5 gives `rsp_s`=1.
- Contention: requesters 0 and 1 both valid continuously from reset. Grants must follow the order 0, 1, 0, 1, and `rsp_id` must match the grant sequence.
- Backpressure: hold `rsp_ready`=0 for 5 cycles. `rsp_*` must stay stable, and `req_ready` must stay 0 throughout. Release → handshake, then IDLE.
- Reset mid-op: assert `rst` in EXEC. `rsp_valid` must be 0 immediately with no response afterwards, and the first grant after reset goes to requester 0.
- Lock (with `ALU_ARB_LOCK_EN`): requester 1 sends two ops with `req_lock`=1 while requester 0 is valid. Both of requester 1's ops must be granted before requester 0's. An illegal opcode within the sequence returns `rsp_err`=1 and `rsp_s`=0.
